// File: rtl/adder_pkg.sv
// Shared types for the 64-bit adder issue stage: operand triple and sizing defaults.
package adder_pkg;
  localparam int ADDER_WIDTH = 64;
  localparam int FIFO_DEPTH  = 2;

  typedef struct packed {
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   cin;
  } add_op_t;
endpackage

// File: rtl/adder64_issue_stage_if.sv
// Operand, adder and result handshake bundle; master is the environment, slave the stage.
interface adder64_issue_stage_if import adder_pkg::*; #(
  parameter int WIDTH = ADDER_WIDTH
);
  logic             in_valid, in_ready, in_cin;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             out_valid, out_ready, out_cout, out_ovf;
  logic [WIDTH-1:0] out_sum;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/adder_op_fifo.sv
// Small synchronous FIFO of operand triples; head is visible combinationally on rdata.
module adder_op_fifo import adder_pkg::*; #(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  add_op_t       wdata,
  input  logic          pop,
  output add_op_t       rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  add_op_t       mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // Storage is not reset; only pointers/occupancy define what is valid.
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/adder64_issue_stage.sv
// Flow-controlled wrapper around an external combinational adder: operand FIFO in, registered result out.
module adder64_issue_stage import adder_pkg::*; #(
  parameter  int WIDTH = ADDER_WIDTH,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  adder64_issue_stage_if.slave bus,
  output logic [CW-1:0] count
);
  add_op_t          wop, head;
  logic             full, empty, push, fire, ovf;
  logic             out_valid_q, out_cout_q, out_ovf_q;
  logic [WIDTH-1:0] out_sum_q;

  assign wop  = '{a: bus.in_a, b: bus.in_b, cin: bus.in_cin};
  // in_ready depends only on registered occupancy, never on out_ready.
  assign push = bus.in_valid & ~full;
  assign fire = ~empty & (~out_valid_q | bus.out_ready);

  adder_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wop),
    .pop   (fire),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.in_ready = ~full;
  assign bus.add_a    = empty ? '0   : head.a;
  assign bus.add_b    = empty ? '0   : head.b;
  assign bus.add_cin  = empty ? 1'b0 : head.cin;

  // Carry into the MSB recovered from the sum bit; XOR with carry-out gives signed overflow.
  assign ovf = bus.add_cout ^ (bus.add_sum[WIDTH-1] ^ bus.add_a[WIDTH-1] ^ bus.add_b[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= bus.add_sum;
      out_cout_q  <= bus.add_cout;
      out_ovf_q   <= ovf;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule
